// File: rtl/id_pair_packer_pkg.sv
// Shared parameter defaults and state encoding for the vector-ID pair packer.
package id_pair_packer_pkg;

  localparam int VEC_ID_WIDTH_DEF = 8;
  localparam int PAIR_W_DEF       = 2 * VEC_ID_WIDTH_DEF;
  localparam int BUS_WIDTH_DEF    = 128;
  localparam int LANES_DEF        = BUS_WIDTH_DEF / PAIR_W_DEF;
  localparam int COUNT_WIDTH_DEF  = 32;

  // HOLD means the output register carries a word not yet taken downstream.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } packer_state_t;

endpackage

// File: rtl/id_pair_packer.sv
// Packs a stream of vector-ID pairs into wide output words, closes words on
// lane overflow, tlast or flush, and reports the pair count of each frame.
module id_pair_packer
  import id_pair_packer_pkg::*;
#(
  parameter int BUS_WIDTH    = LANES_DEF * PAIR_W_DEF,
  parameter int VEC_ID_WIDTH = PAIR_W_DEF / 2,
  parameter int COUNT_WIDTH  = COUNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [2*VEC_ID_WIDTH-1:0] s_tdata,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic [BUS_WIDTH-1:0]      m_tdata,
  output logic [BUS_WIDTH/8-1:0]    m_tkeep,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  input  logic                      flush,
  output logic [COUNT_WIDTH-1:0]    pair_count,
  output logic                      count_valid
);

  localparam int PAIR_W         = 2 * VEC_ID_WIDTH;
  localparam int LANES          = BUS_WIDTH / PAIR_W;
  localparam int KEEP_W         = BUS_WIDTH / 8;
  localparam int BYTES_PER_PAIR = PAIR_W / 8;
  localparam int LANE_CW        = $clog2(LANES + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  packer_state_t            r_state;
  logic [BUS_WIDTH-1:0]     r_acc;
  logic [LANE_CW-1:0]       r_lanes;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic                     r_flush_pend;
  logic [BUS_WIDTH-1:0]     r_m_tdata;
  logic [KEEP_W-1:0]        r_m_tkeep;
  logic                     r_m_tlast;
  logic [COUNT_WIDTH-1:0]   r_pair_count;
  logic                     r_count_valid;

  logic                     w_out_free;
  logic                     w_accept;
  logic                     w_flush_req;
  logic                     w_flush_exec;
  logic                     w_frame_end;
  logic                     w_close;
  logic [LANE_CW-1:0]       w_lanes_next;
  logic [BUS_WIDTH-1:0]     w_acc_next;
  logic [KEEP_W-1:0]        w_keep_next;
  logic [COUNT_WIDTH-1:0]   w_count_next;

  assign w_out_free   = (r_state != HOLD) || m_tready;
  assign s_tready     = rstn && w_out_free;
  assign w_accept     = s_tvalid && s_tready;
  // A flush seen while stalled waits in r_flush_pend until the output frees.
  assign w_flush_req  = flush || r_flush_pend;
  assign w_flush_exec = w_flush_req && w_out_free;
  assign w_frame_end  = (w_accept && s_tlast) || w_flush_exec;
  assign w_lanes_next = r_lanes + LANE_CW'(w_accept);
  assign w_close      = w_frame_end || (w_accept && (w_lanes_next == LANE_CW'(LANES)));
  assign w_count_next = (w_accept && (r_count != COUNT_MAX)) ? r_count + COUNT_WIDTH'(1) : r_count;

  always_comb begin
    w_acc_next = r_acc;
    if (w_accept) begin
      w_acc_next[r_lanes*PAIR_W +: PAIR_W] = s_tdata;
    end
  end

  always_comb begin
    w_keep_next = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      w_keep_next[i] = (i < int'(w_lanes_next) * BYTES_PER_PAIR);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_acc         <= '0;
      r_lanes       <= '0;
      r_count       <= '0;
      r_flush_pend  <= 1'b0;
      r_m_tdata     <= '0;
      r_m_tkeep     <= '0;
      r_m_tlast     <= 1'b0;
      r_pair_count  <= '0;
      r_count_valid <= 1'b0;
    end else begin
      r_count_valid <= 1'b0;
      r_flush_pend  <= w_flush_req && !w_out_free;
      if (w_close) begin
        r_m_tdata <= w_acc_next;
        r_m_tkeep <= w_keep_next;
        r_m_tlast <= w_frame_end;
        r_acc     <= '0;
        r_lanes   <= '0;
        r_state   <= HOLD;
      end else begin
        r_acc   <= w_acc_next;
        r_lanes <= w_lanes_next;
        if (r_state == HOLD && !m_tready) begin
          r_state <= HOLD;
        end else if (w_lanes_next == '0) begin
          r_state <= IDLE;
        end else begin
          r_state <= FILL;
        end
      end
      // Count pulse is registered alongside the closing word so both rise together.
      if (w_frame_end) begin
        r_pair_count  <= w_count_next;
        r_count_valid <= 1'b1;
        r_count       <= '0;
      end else begin
        r_count <= w_count_next;
      end
    end
  end

  assign m_tvalid    = (r_state == HOLD);
  assign m_tdata     = r_m_tdata;
  assign m_tkeep     = r_m_tkeep;
  assign m_tlast     = r_m_tlast;
  assign pair_count  = r_pair_count;
  assign count_valid = r_count_valid;

endmodule

// File: tb/tb_id_pair_packer.sv
// Scoreboard bench for id_pair_packer: a bench-side packing model queues the
// expected words and frame counts as pairs are accepted.
module tb_id_pair_packer;

  localparam int LANES  = 8;
  localparam int PAIR_W = 16;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } word_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [15:0]  s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tready;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready = 1'b1;
  logic         flush = 1'b0;
  logic [31:0]  pair_count;
  logic         count_valid;

  word_t        expWords[$];
  int unsigned  expCounts[$];
  int           compareCount = 0;
  int           mismatchCount = 0;
  logic [127:0] modelAcc = '0;
  int           modelN = 0;
  int unsigned  modelPairs = 0;
  logic         prevStall = 1'b0;
  logic         randReady = 1'b0;
  logic [127:0] stallWord;

  id_pair_packer dut (
    .clk(clk), .rstn(rstn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .flush(flush),
    .pair_count(pair_count), .count_valid(count_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] keepFor(input int n);
    logic [31:0] k;
    k = (32'd1 << (n * 2)) - 32'd1;
    return k[15:0];
  endfunction

  task automatic modelClose(input logic isEnd);
    word_t w;
    w.data = modelAcc;
    w.keep = keepFor(modelN);
    w.last = isEnd;
    expWords.push_back(w);
    modelAcc = '0;
    modelN = 0;
    if (isEnd) begin
      expCounts.push_back(modelPairs);
      modelPairs = 0;
    end
  endtask

  task automatic modelAccept(input logic [15:0] d, input logic last, input logic fl);
    modelAcc[modelN*PAIR_W +: PAIR_W] = d;
    modelN++;
    modelPairs++;
    if (modelN == LANES || last || fl) modelClose(last || fl);
  endtask

  // Output side: every handshake pops one expected word.
  always @(negedge clk) begin
    if (rstn && m_tvalid && m_tready) begin
      if (expWords.size() == 0) begin
        checkOutput("extra_word", 128'(expWords.size()), 128'(1));
      end else begin
        word_t w;
        w = expWords.pop_front();
        checkOutput("tdata", m_tdata, w.data);
        checkOutput("tkeep", 128'(m_tkeep), 128'(w.keep));
        checkOutput("tlast", 128'(m_tlast), 128'(w.last));
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && count_valid) begin
      if (expCounts.size() == 0) begin
        checkOutput("extra_count_valid", 128'(expCounts.size()), 128'(1));
      end else begin
        checkOutput("pair_count", 128'(pair_count), 128'(expCounts.pop_front()));
        checkOutput("cv_with_tvalid_tlast", 128'({m_tvalid, m_tlast}), 128'(2'b11));
        checkOutput("cv_on_first_valid", 128'(prevStall), 128'(0));
      end
    end
    prevStall = m_tvalid && !m_tready;
  end

  task automatic sendPair(input logic [15:0] d, input logic last, input logic withFlush);
    logic accepted;
    accepted = 1'b0;
    s_tdata = d;
    s_tlast = last;
    s_tvalid = 1'b1;
    flush = withFlush;
    for (int c = 0; c < 300 && !accepted; c++) begin
      @(negedge clk);
      accepted = s_tready;
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    if (!accepted) checkOutput("send_timeout", 128'(accepted), 128'(1));
    else modelAccept(d, last, withFlush);
  endtask

  task automatic sendFlush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    modelClose(1'b1);
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && (expWords.size() != 0 || expCounts.size() != 0); c++) @(negedge clk);
    checkOutput("drain_words", 128'(expWords.size()), 128'(0));
    checkOutput("drain_counts", 128'(expCounts.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    // Full frame of 16 sequential pairs, then a short 3-pair frame.
    for (int i = 1; i <= 16; i++) sendPair(16'(i), (i == 16), 1'b0);
    drain();
    sendPair(16'hA1B2, 1'b0, 1'b0);
    sendPair(16'hC3D4, 1'b0, 1'b0);
    sendPair(16'hE5F6, 1'b1, 1'b0);
    drain();

    // Flush alone, flush after a partial word, flush coinciding with tlast.
    sendFlush();
    drain();
    sendPair(16'h1111, 1'b0, 1'b0);
    sendPair(16'h2222, 1'b0, 1'b0);
    sendFlush();
    drain();
    sendPair(16'h3333, 1'b0, 1'b0);
    sendPair(16'h4444, 1'b1, 1'b1);
    drain();

    // Long stall with continuous input.
    for (int i = 0; i < LANES; i++) stallWord[i*PAIR_W +: PAIR_W] = 16'h0101 + 16'(i);
    m_tready = 1'b0;
    fork
      for (int i = 0; i < 16; i++) sendPair(16'h0101 + 16'(i), (i == 15), 1'b0);
      begin
        for (int c = 1; c <= 20; c++) begin
          @(negedge clk);
          if (c == 12 || c == 16 || c == 20) begin
            checkOutput("stall_s_tready", 128'(s_tready), 128'(0));
            checkOutput("stall_m_tvalid", 128'(m_tvalid), 128'(1));
            checkOutput("stall_m_tdata", m_tdata, stallWord);
          end
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();

    // Flush arriving while the output is stalled must wait for release.
    m_tready = 1'b0;
    for (int i = 0; i < LANES; i++) sendPair(16'h0300 + 16'(i), 1'b0, 1'b0);
    sendFlush();
    repeat (3) @(posedge clk);
    #1;
    m_tready = 1'b1;
    drain();

    // Random backpressure with random data, including a flush riding on a pair.
    randReady = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) sendPair(16'($urandom), (i == 9 || i == 23), (i == 15));
        randReady = 1'b0;
      end
      while (randReady) begin
        @(posedge clk);
        #1;
        if (randReady) m_tready = ($urandom_range(0, 3) != 0);
      end
    join
    m_tready = 1'b1;
    drain();
  endtask

  task automatic checkResetState(input string tag);
    @(negedge clk);
    checkOutput({tag, "_s_tready"}, 128'(s_tready), 128'(0));
    checkOutput({tag, "_m_tvalid"}, 128'(m_tvalid), 128'(0));
    checkOutput({tag, "_m_tdata"}, m_tdata, 128'(0));
    checkOutput({tag, "_m_tkeep"}, 128'(m_tkeep), 128'(0));
    checkOutput({tag, "_m_tlast"}, 128'(m_tlast), 128'(0));
    checkOutput({tag, "_count_valid"}, 128'(count_valid), 128'(0));
    checkOutput({tag, "_pair_count"}, 128'(pair_count), 128'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    checkResetState("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_s_tready", 128'(s_tready), 128'(1));
    @(posedge clk);
    #1;

    applyStimulus();

    // Reset mid-frame discards the partial word.
    for (int i = 0; i < 5; i++) sendPair(16'h0500 + 16'(i), 1'b0, 1'b0);
    rstn = 1'b0;
    modelAcc = '0;
    modelN = 0;
    modelPairs = 0;
    repeat (2) @(posedge clk);
    checkResetState("midreset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("midreset_release_s_tready", 128'(s_tready), 128'(1));
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) sendPair(16'h0201 + 16'(i), (i == 7), 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/id_pair_packer.md
ID_PAIR_PACKER -- requirements
Module: id_pair_packer

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 128, output word width in bits.
REQ-002 SHALL have parameter VEC_ID_WIDTH, default 8, width of one vector ID.
REQ-003 SHALL have parameter COUNT_WIDTH, default 32, width of the per-frame pair counter.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports s_tdata input 2*VEC_ID_WIDTH, s_tvalid input 1, s_tlast input 1, s_tready output 1; ID-pair AXI-Stream sink.
REQ-007 SHALL have ports m_tdata output BUS_WIDTH, m_tkeep output BUS_WIDTH/8, m_tvalid output 1, m_tlast output 1, m_tready input 1; packed-word AXI-Stream source.
REQ-008 SHALL have port flush  input  1  single-cycle end-of-frame request for frames with no pending tlast.
REQ-009 SHALL have ports pair_count output COUNT_WIDTH and count_valid output 1; pairs in the last completed frame, qualified by a 1-cycle pulse.

Function
REQ-010 SHALL define PAIR_W = 2*VEC_ID_WIDTH and LANES = BUS_WIDTH/PAIR_W (8 at defaults); BUS_WIDTH SHALL be a multiple of PAIR_W, and PAIR_W a multiple of 8.
REQ-011 SHALL accept a pair when s_tvalid && s_tready and place the k-th pair of a word at m_tdata[k*PAIR_W +: PAIR_W], k from 0.
REQ-012 SHALL drive s_tready = !(m_tvalid && !m_tready); the block never drops or duplicates a pair.
REQ-013 SHALL move the word to the output register on the same edge that accepts the LANES-th pair or any pair with s_tlast; m_tvalid rises the next cycle (latency 1).
REQ-014 SHALL set m_tkeep lower n*PAIR_W/8 bits to 1 and the rest to 0 for a word of n pairs; unused lanes SHALL be zero.
REQ-015 SHALL set m_tlast only on the word closing a frame (s_tlast or flush).
REQ-016 SHALL hold m_tdata/m_tkeep/m_tlast stable while m_tvalid && !m_tready.
REQ-017 SHALL, on flush with partial accumulator, emit that partial word with m_tlast=1; on flush with empty accumulator, emit one word with m_tkeep=0, m_tdata=0, m_tlast=1.
REQ-018 SHALL, if flush and an accepted s_tlast coincide, treat them as a single frame end (no extra empty word).
REQ-019 SHALL, if flush arrives while s_tready=0, register it as pending and execute it at the first cycle the output register frees.
REQ-020 SHALL count accepted pairs per frame, saturating at 2^COUNT_WIDTH-1; at frame end latch into pair_count, pulse count_valid on the same cycle m_tvalid first rises for the closing word, and clear the counter.
REQ-021 SHALL implement states IDLE (accumulator empty), FILL (1..LANES-1 pairs held), HOLD (output register full, stalled); IDLE->FILL on accept, FILL->IDLE on word close, any->HOLD when output full and !m_tready, HOLD->previous on m_tready.

Reset
REQ-022 SHALL, while rstn=0, clear m_tvalid, m_tlast, m_tkeep, m_tdata, s_tready=0, count_valid=0, pair_count=0, lane counter, pair counter and pending flush.
REQ-023 SHALL discard any partially packed word on reset mid-frame; s_tready SHALL return to 1 the first cycle after rstn rises.

Structure
REQ-024 SHALL take PAIR_W, LANES and COUNT_WIDTH defaults from the shared tanimoto parameter package used by the top level.
REQ-025 SHALL be one module; no sub-module is required.

Verification
REQ-026 SHALL verify: 16 pairs 0x0001..0x0010, last on 16th, m_tready=1 -> 2 words, tkeep=0xFFFF, tlast only on 2nd, pair_count=16.
REQ-027 SHALL verify: 3 pairs 0xA1B2,0xC3D4,0xE5F6 with tlast on 3rd -> one word, lanes 0..2 set, tkeep=0x003F, upper 80 bits zero, tlast=1, pair_count=3.
REQ-028 SHALL verify: flush with no pairs -> one word tkeep=0x0000, tdata=0, tlast=1, pair_count=0, count_valid pulses once.
REQ-029 SHALL verify: m_tready=0 for 20 cycles with continuous input -> s_tready=0 after 8 more pairs, m_tdata stable, no pair loss when released.
REQ-030 SHALL verify: rstn=0 after 5 pairs, then 8 new pairs with tlast -> only new pairs output, one word, pair_count=8.
